// File: rtl/mt_register_file_ctx.sv
// ----------------------------------------------------------------------------
// mt_register_file_ctx
//
// Multithreaded register file: one context of REGS registers per hardware
// thread, stored as a flat array indexed by {thread, register}.  Two
// combinational read ports with write-through bypass serve the ID stage, and
// one synchronous write port serves the WB stage.  A context-clear sequencer
// wipes one thread's registers, one per cycle, while the other threads keep
// reading and writing.
//
// Optional feature macro: RF_ZERO_REG_EN
//   defined   : register 0 of every thread is hardwired to zero (reads return
//               0, writes are discarded, no bypass on address 0).
//   undefined : register 0 is an ordinary register.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   clr_n         asynchronous active-low reset
//   thread_rd     thread selecting both read ports
//   r1addr/r2addr read port register addresses
//   r1data/r2data combinational read data
//   thread_wr     write thread
//   waddr/wdata   write register address / data
//   wena          write enable
//   ctx_clr_req   request a context clear of thread ctx_clr_tid
//   ctx_clr_tid   thread to clear, captured when the request is accepted
//   ctx_clr_busy  high while the clear sweep is running
//   ctx_clr_done  one-cycle pulse after the last register has been cleared
// ----------------------------------------------------------------------------
module mt_register_file_ctx #(
    parameter int DATA_W      = 32,
    parameter int NUM_THREADS = 4,
    parameter int REGS        = 32,
    localparam int TID_W      = $clog2(NUM_THREADS),
    localparam int RA_W       = $clog2(REGS)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [TID_W-1:0]  thread_rd,
    input  logic [RA_W-1:0]   r1addr,
    input  logic [RA_W-1:0]   r2addr,
    output logic [DATA_W-1:0] r1data,
    output logic [DATA_W-1:0] r2data,
    input  logic [TID_W-1:0]  thread_wr,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wena,
    input  logic              ctx_clr_req,
    input  logic [TID_W-1:0]  ctx_clr_tid,
    output logic              ctx_clr_busy,
    output logic              ctx_clr_done
);

    localparam int DEPTH = NUM_THREADS * REGS;
    localparam int FI_W  = TID_W + RA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TID_W-1:0]  clr_tid;
    logic [RA_W-1:0]   idx;

    logic [DATA_W-1:0] rf [DEPTH];

    logic [FI_W-1:0]   w_index;
    logic [FI_W-1:0]   rd1_index;
    logic [FI_W-1:0]   rd2_index;
    logic [FI_W-1:0]   clr_index;

    logic              clearing;
    logic              rd_hidden;
    logic              wr_blocked;
    logic              wr_is_zero;
    logic              r1_is_zero;
    logic              r2_is_zero;
    logic              wr_eff;

    assign w_index   = {thread_wr, waddr};
    assign rd1_index = {thread_rd, r1addr};
    assign rd2_index = {thread_rd, r2addr};
    assign clr_index = {clr_tid, idx};

    assign clearing   = (state == S_CLEAR);
    // While a thread is being swept its whole context reads as zero, so a
    // half-cleared context is never observable.
    assign rd_hidden  = clearing && (thread_rd == clr_tid);
    // Writes into the thread under clear are dropped; this also guarantees
    // the external write and the sweep write never target the same entry.
    assign wr_blocked = clearing && (thread_wr == clr_tid);

`ifdef RF_ZERO_REG_EN
    assign wr_is_zero = (waddr == '0);
    assign r1_is_zero = (r1addr == '0);
    assign r2_is_zero = (r2addr == '0);
`else
    assign wr_is_zero = 1'b0;
    assign r1_is_zero = 1'b0;
    assign r2_is_zero = 1'b0;
`endif

    assign wr_eff = wena && !wr_blocked && !wr_is_zero;

    // Clear sequencer next-state and status outputs.  The sweep index is
    // compared before its increment, so CLEAR spans exactly REGS cycles.
    always_comb begin
        state_nxt    = state;
        ctx_clr_busy = 1'b0;
        ctx_clr_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctx_clr_req) begin
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ctx_clr_busy = 1'b1;
                if (idx == RA_W'(REGS - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ctx_clr_done = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state, captured target thread and sweep index.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= S_IDLE;
            clr_tid <= '0;
            idx     <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && ctx_clr_req) begin
                clr_tid <= ctx_clr_tid;
                idx     <= '0;
            end else if (clearing) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Register storage.  The external write and the sweep write may both
    // happen in one cycle; they always address different threads.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wr_eff) begin
                rf[w_index] <= wdata;
            end
            if (clearing) begin
                rf[clr_index] <= '0;
            end
        end
    end

    // Read ports: array value, overridden by a same-cycle effective write,
    // overridden by zero for a hidden context or the hardwired register.
    always_comb begin
        r1data = rf[rd1_index];
        if (wr_eff && (w_index == rd1_index)) begin
            r1data = wdata;
        end
        if (rd_hidden || r1_is_zero) begin
            r1data = '0;
        end
    end

    always_comb begin
        r2data = rf[rd2_index];
        if (wr_eff && (w_index == rd2_index)) begin
            r2data = wdata;
        end
        if (rd_hidden || r2_is_zero) begin
            r2data = '0;
        end
    end

endmodule

// File: tb/tb_mt_register_file_ctx.sv
// ----------------------------------------------------------------------------
// tb_mt_register_file_ctx
//
// Self-checking bench for mt_register_file_ctx with default parameters.
// A behavioural model (plain 2-D array plus the cycle number at which the
// last clear was accepted) predicts every output on every cycle; a few
// hand-computed literals pin the model itself.
// ----------------------------------------------------------------------------
module tb_mt_register_file_ctx;

    localparam int DATA_W      = 32;
    localparam int NUM_THREADS = 4;
    localparam int REGS        = 32;
    localparam int TID_W       = 2;
    localparam int RA_W        = 5;

    logic              clk = 1'b0;
    logic              clr_n;
    logic [TID_W-1:0]  thread_rd;
    logic [RA_W-1:0]   r1addr;
    logic [RA_W-1:0]   r2addr;
    logic [DATA_W-1:0] r1data;
    logic [DATA_W-1:0] r2data;
    logic [TID_W-1:0]  thread_wr;
    logic [RA_W-1:0]   waddr;
    logic [DATA_W-1:0] wdata;
    logic              wena;
    logic              ctx_clr_req;
    logic [TID_W-1:0]  ctx_clr_tid;
    logic              ctx_clr_busy;
    logic              ctx_clr_done;

    mt_register_file_ctx #(
        .DATA_W      (DATA_W),
        .NUM_THREADS (NUM_THREADS),
        .REGS        (REGS)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .thread_rd    (thread_rd),
        .r1addr       (r1addr),
        .r2addr       (r2addr),
        .r1data       (r1data),
        .r2data       (r2data),
        .thread_wr    (thread_wr),
        .waddr        (waddr),
        .wdata        (wdata),
        .wena         (wena),
        .ctx_clr_req  (ctx_clr_req),
        .ctx_clr_tid  (ctx_clr_tid),
        .ctx_clr_busy (ctx_clr_busy),
        .ctx_clr_done (ctx_clr_done)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: register contents, current cycle number, and the cycle
    // in which the last clear request was accepted.  Busy covers the REGS
    // cycles after acceptance, done the single cycle after that.
    logic [DATA_W-1:0] mrf [NUM_THREADS][REGS];
    int                cur       = 0;
    int                acc       = 0;
    int                m_tid     = 0;
    bit                acc_valid = 1'b0;

    logic [DATA_W-1:0] last_r1;
    logic [DATA_W-1:0] last_r2;
    logic              last_busy;
    logic              last_done;
    int                busy_cnt;
    int                done_cnt;

    function automatic bit m_busy();
        return acc_valid && (cur > acc) && (cur <= acc + REGS);
    endfunction

    function automatic bit m_done();
        return acc_valid && (cur == acc + REGS + 1);
    endfunction

    function automatic bit m_wr_eff();
        bit e;
        e = wena;
        if (m_busy() && (int'(thread_wr) == m_tid)) e = 1'b0;
`ifdef RF_ZERO_REG_EN
        if (waddr == 0) e = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [DATA_W-1:0] m_read(input int addr);
        int tid;
        tid = int'(thread_rd);
        if (m_busy() && (tid == m_tid)) return '0;
`ifdef RF_ZERO_REG_EN
        if (addr == 0) return '0;
`endif
        if (m_wr_eff() && (int'(thread_wr) == tid) && (int'(waddr) == addr)) return wdata;
        return mrf[tid][addr];
    endfunction

    // One comparison; reports and counts a mismatch.
    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare all DUT outputs with the model for the current inputs.
    task automatic checkOutput();
        check("r1data", r1data, m_read(int'(r1addr)));
        check("r2data", r2data, m_read(int'(r2addr)));
        check("ctx_clr_busy", {31'b0, ctx_clr_busy}, {31'b0, m_busy()});
        check("ctx_clr_done", {31'b0, ctx_clr_done}, {31'b0, m_done()});
        last_r1   = r1data;
        last_r2   = r2data;
        last_busy = ctx_clr_busy;
        last_done = ctx_clr_done;
    endtask

    // Advance the model across a rising edge using the inputs just applied.
    task automatic modelEdge();
        bit accept;
        accept = !m_busy() && !m_done() && ctx_clr_req;
        if (m_wr_eff()) mrf[thread_wr][waddr] = wdata;
        if (accept) begin
            for (int a = 0; a < REGS; a++) mrf[ctx_clr_tid][a] = '0;
            m_tid     = int'(ctx_clr_tid);
            acc       = cur;
            acc_valid = 1'b1;
        end
        cur++;
    endtask

    // Drive one cycle of inputs (shortly after an edge), check outputs at
    // the falling edge, then step the model across the next rising edge.
    task automatic applyStimulus(input logic [TID_W-1:0] trd, input logic [RA_W-1:0] a1,
                                 input logic [RA_W-1:0] a2, input logic [TID_W-1:0] twr,
                                 input logic [RA_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic we, input logic req, input logic [TID_W-1:0] ctid);
        thread_rd   = trd;
        r1addr      = a1;
        r2addr      = a2;
        thread_wr   = twr;
        waddr       = wa;
        wdata       = wd;
        wena        = we;
        ctx_clr_req = req;
        ctx_clr_tid = ctid;
        #4;
        checkOutput();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idleCycle(input logic [TID_W-1:0] trd, input logic [RA_W-1:0] a1, input logic [RA_W-1:0] a2);
        applyStimulus(trd, a1, a2, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    // Random reads only, tallying the clear status seen each cycle.
    task automatic countCycles(input int n);
        for (int i = 0; i < n; i++) begin
            idleCycle(TID_W'($urandom), RA_W'($urandom), RA_W'($urandom));
            busy_cnt += int'(last_busy);
            done_cnt += int'(last_done);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic doReset();
        thread_rd   = '0;
        r1addr      = 5'd4;
        r2addr      = 5'd9;
        thread_wr   = '0;
        waddr       = '0;
        wdata       = '0;
        wena        = 1'b0;
        ctx_clr_req = 1'b0;
        ctx_clr_tid = '0;
        clr_n       = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++)
            for (int a = 0; a < REGS; a++) mrf[t][a] = '0;
        acc_valid = 1'b0;
        #4;
        checkOutput();
        check("reset_busy_lit", {31'b0, ctx_clr_busy}, 32'd0);
        check("reset_r1_lit", r1data, 32'd0);
        @(posedge clk);
        cur++;
        #1;
        clr_n = 1'b1;
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        clr_n       = 1'b0;
        thread_rd   = '0;
        r1addr      = '0;
        r2addr      = '0;
        thread_wr   = '0;
        waddr       = '0;
        wdata       = '0;
        wena        = 1'b0;
        ctx_clr_req = 1'b0;
        ctx_clr_tid = '0;
        @(posedge clk);
        #1;
        doReset();

        // Basic write, bypass and thread isolation.
        applyStimulus(2'd2, 5'd5, 5'd5, 2'd2, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, '0);
        check("bypass_lit", last_r1, 32'hDEADBEEF);
        idleCycle(2'd2, 5'd5, 5'd1);
        check("t2r5_lit", last_r1, 32'hDEADBEEF);
        idleCycle(2'd1, 5'd5, 5'd1);
        check("t1r5_lit", last_r1, 32'h0);

        // Fill every context with a recognisable pattern.
        for (int t = 0; t < NUM_THREADS; t++)
            for (int a = 0; a < REGS; a++)
                applyStimulus(TID_W'($urandom), RA_W'($urandom), RA_W'($urandom),
                              TID_W'(t), RA_W'(a), (DATA_W'(t) << 28) | DATA_W'(a), 1'b1, 1'b0, '0);
        idleCycle(2'd3, 5'd7, 5'd1);
        check("fill_t3r7_lit", last_r1, 32'h30000007);

        // Clear thread 1, with dropped/landing writes and ignored requests.
        applyStimulus(2'd1, 5'd3, 5'd4, '0, '0, '0, 1'b0, 1'b1, 2'd1);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                applyStimulus(2'd1, 5'd3, 5'd4, 2'd1, 5'd3, 32'h55, 1'b1, 1'b0, '0);
                check("dropped_wr_lit", last_r1, 32'h0);
            end else if (i == 3) begin
                applyStimulus(2'd3, 5'd3, 5'd4, 2'd3, 5'd3, 32'h66, 1'b1, 1'b0, '0);
                check("other_wr_bypass_lit", last_r1, 32'h66);
            end else if (i == 5) begin
                applyStimulus(2'd0, 5'd4, 5'd9, '0, '0, '0, 1'b0, 1'b1, 2'd0);
            end else if (m_done()) begin
                applyStimulus(2'd2, 5'd6, 5'd7, '0, '0, '0, 1'b0, 1'b1, 2'd2);
            end else begin
                idleCycle(TID_W'($urandom), RA_W'($urandom), RA_W'($urandom));
            end
            busy_cnt += int'(last_busy);
            done_cnt += int'(last_done);
        end
        check("clear_busy_cycles", busy_cnt, 32);
        check("clear_done_pulses", done_cnt, 1);
        idleCycle(2'd0, 5'd4, 5'd9);
        check("t0_intact_lit", last_r1, 32'h00000004);
        check("t0_intact2_lit", last_r2, 32'h00000009);
        idleCycle(2'd1, 5'd3, 5'd31);
        check("t1_cleared_lit", last_r1, 32'h0);
        idleCycle(2'd3, 5'd3, 5'd1);
        check("t3_write_lit", last_r1, 32'h66);
        idleCycle(2'd2, 5'd6, 5'd1);
        check("t2_intact_lit", last_r1, 32'h20000006);

        // Reset in the middle of a clear sweep, then a fresh clear.
        applyStimulus(2'd2, 5'd6, 5'd1, '0, '0, '0, 1'b0, 1'b1, 2'd2);
        for (int i = 0; i < 10; i++) idleCycle(2'd0, 5'd4, 5'd1);
        doReset();
        busy_cnt = 0;
        done_cnt = 0;
        countCycles(6);
        check("post_reset_busy", busy_cnt, 0);
        check("post_reset_done", done_cnt, 0);
        applyStimulus(2'd3, 5'd2, 5'd1, 2'd3, 5'd2, 32'h1234, 1'b1, 1'b1, 2'd3);
        countCycles(40);
        check("reclear_busy_cycles", busy_cnt, 32);
        check("reclear_done_pulses", done_cnt, 1);
        idleCycle(2'd3, 5'd2, 5'd1);
        check("accept_edge_wr_wiped_lit", last_r1, 32'h0);

        // Register 0 behaviour, including same-cycle bypass.
        applyStimulus(2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0, '0);
`ifdef RF_ZERO_REG_EN
        check("r0_bypass_lit", last_r1, 32'h0);
`else
        check("r0_bypass_lit", last_r1, 32'hFFFFFFFF);
`endif
        idleCycle(2'd0, 5'd0, 5'd1);
`ifdef RF_ZERO_REG_EN
        check("r0_read_lit", last_r1, 32'h0);
`else
        check("r0_read_lit", last_r1, 32'hFFFFFFFF);
`endif

        // Randomized soak with frequent read/write address collisions.
        for (int i = 0; i < 1500; i++) begin
            logic [TID_W-1:0]  twr;
            logic [RA_W-1:0]   wa;
            logic [TID_W-1:0]  trd;
            logic [RA_W-1:0]   a1;
            twr = TID_W'($urandom);
            wa  = RA_W'($urandom_range(0, 7));
            trd = TID_W'($urandom);
            a1  = RA_W'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                trd = twr;
                a1  = wa;
            end
            applyStimulus(trd, a1, RA_W'($urandom), twr, wa, DATA_W'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          TID_W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
